// File: rtl/dict_access_ctrl.sv
// LZW dictionary map RAM sequencer: lookup/insert, code counter, flush sweep.
// Optional per-kind response counters under `DICT_STATS_EN`.
module dict_access_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int DEPTH      = 2048,
   parameter int FIRST_CODE = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_insert,
   output logic                  rsp_valid,
   output logic                  rsp_hit,
   output logic [ADDR_WIDTH-1:0] rsp_code,
   input  logic                  flush,
   output logic                  dict_full,
   output logic                  busy,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [ADDR_WIDTH-1:0] ram_wdata,
   input  logic [ADDR_WIDTH-1:0] ram_rdata
`ifdef DICT_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses,
   output logic [31:0]           stat_inserts
`endif
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MAX_CODE = CW'(DEPTH - 1);
   localparam logic [CW-1:0] FIRST = CW'(FIRST_CODE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE, RD, CHK, WR, RSP, CLR
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  ins_q;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [CW-1:0]         next_code;
   logic                  did_ins;
   logic                  rd_hit;
   logic                  clr_last;

   // next_code is one bit wider than a code, so it saturates visibly
   assign dict_full = next_code[ADDR_WIDTH] | (next_code > MAX_CODE);
   assign busy      = (state != IDLE);
   assign rd_hit    = (ram_rdata != '0);
   assign clr_last  = (clr_addr == LAST_ADDR);

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (state)
         IDLE: begin
            req_ready = !flush;
            if (flush)          state_nx = CLR;
            else if (req_valid) state_nx = RD;
         end
         RD: begin
            ram_cs   = 1'b1;
            ram_addr = addr_q;
            state_nx = CHK;
         end
         CHK: begin
            if (rd_hit)                   state_nx = RSP;
            else if (ins_q && !dict_full) state_nx = WR;
            else                          state_nx = RSP;
         end
         WR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = next_code[ADDR_WIDTH-1:0];
            state_nx  = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         CLR: begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_addr;
            if (clr_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         ins_q     <= 1'b0;
         clr_addr  <= '0;
         next_code <= FIRST;
         rsp_hit   <= 1'b0;
         rsp_code  <= '0;
         did_ins   <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               clr_addr <= '0;
               if (!flush && req_valid) begin
                  addr_q <= req_addr;
                  ins_q  <= req_insert;
               end
            end
            CHK: begin
               if (rd_hit) begin
                  rsp_hit  <= 1'b1;
                  rsp_code <= ram_rdata;
                  did_ins  <= 1'b0;
               end else if (!(ins_q && !dict_full)) begin
                  rsp_hit  <= 1'b0;
                  rsp_code <= '0;
                  did_ins  <= 1'b0;
               end
            end
            WR: begin
               next_code <= next_code + 1'b1;
               rsp_hit   <= 1'b0;
               rsp_code  <= next_code[ADDR_WIDTH-1:0];
               did_ins   <= 1'b1;
            end
            CLR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_last) next_code <= FIRST;
            end
            default: ;
         endcase
      end
   end

`ifdef DICT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hits    <= '0;
         stat_misses  <= '0;
         stat_inserts <= '0;
      end else if (state == CLR && clr_last) begin
         stat_hits    <= '0;
         stat_misses  <= '0;
         stat_inserts <= '0;
      end else if (state == RSP) begin
         if (rsp_hit && stat_hits != '1)
            stat_hits <= stat_hits + 1;
         if (!rsp_hit && stat_misses != '1)
            stat_misses <= stat_misses + 1;
         if (did_ins && stat_inserts != '1)
            stat_inserts <= stat_inserts + 1;
      end
   end
`endif

endmodule

// File: tb/tb_dict_access_ctrl.sv
// Scoreboard bench for dict_access_ctrl with a behavioural sync RAM.
// Stat counter checks compile in when DICT_STATS_EN is defined.
module tb_dict_access_ctrl;
   localparam int AW    = 11;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_insert = 1'b0;
   logic          rsp_valid;
   logic          rsp_hit;
   logic [AW-1:0] rsp_code;
   logic          flush = 1'b0;
   logic          dict_full;
   logic          busy;
   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [AW-1:0] ram_wdata;
   logic [AW-1:0] ram_rdata = '0;
`ifdef DICT_STATS_EN
   logic [31:0]   stat_hits;
   logic [31:0]   stat_misses;
   logic [31:0]   stat_inserts;
`endif

   dict_access_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_insert(req_insert),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
      .rsp_code(rsp_code), .flush(flush),
      .dict_full(dict_full), .busy(busy),
      .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef DICT_STATS_EN
      ,
      .stat_hits(stat_hits),
      .stat_misses(stat_misses),
      .stat_inserts(stat_inserts)
`endif
   );

   always #5 clk = ~clk;

   logic [AW-1:0] mem [DEPTH] = '{default: '0};
   int wr_cnt = 0;
   int cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_cs && ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wr_cnt <= wr_cnt + 1;
      end else if (ram_cs) begin
         ram_rdata <= mem[ram_addr];
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic          hit;
      logic [AW-1:0] code;
      int            lat;
      int            start;
   } exp_t;

   exp_t q[$];

   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid) begin
         if (q.size() == 0) begin
            check("spurious_rsp", 1, 0);
         end else begin
            e = q.pop_front();
            check("rsp_hit", rsp_hit, e.hit);
            check("rsp_code", rsp_code, e.code);
            check("rsp_lat", cyc - e.start, e.lat);
         end
      end
   end

   task automatic do_req(input logic [AW-1:0] a, input logic ins,
                         input logic eh, input logic [AW-1:0] ec,
                         input int lat);
      exp_t e;
      @(negedge clk);
      req_valid  = 1'b1;
      req_addr   = a;
      req_insert = ins;
      e.hit = eh; e.code = ec; e.lat = lat; e.start = cyc;
      q.push_back(e);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_addr   = AW'($urandom);
      req_insert = 1'($urandom);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("rsp_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   initial begin
      int w0;
      int seq_err;
      bit found;

      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_full", dict_full, 0);
      check("rst_hit", rsp_hit, 0);
      check("rst_code", rsp_code, 0);
      check("rst_cs", ram_cs, 0);
      rst = 1'b0;

      w0 = wr_cnt;
      do_req(5, 1, 0, 256, 4);
      check("ins_wr_cnt", wr_cnt - w0, 1);
      check("ins_mem5", mem[5], 256);

      w0 = wr_cnt;
      do_req(5, 1, 1, 256, 3);
      check("hit_no_wr", wr_cnt - w0, 0);
`ifdef DICT_STATS_EN
      check("st_hits", stat_hits, 1);
      check("st_misses", stat_misses, 1);
      check("st_inserts", stat_inserts, 1);
`endif

      do_req(7, 0, 0, 0, 3);

      for (int i = 0; i < 1791; i++)
         do_req(AW'(8 + i), 1, 0, AW'(257 + i), 4);
      check("full_flag", dict_full, 1);

      w0 = wr_cnt;
      do_req(2000, 1, 0, 0, 3);
      check("full_no_wr", wr_cnt - w0, 0);
      check("full_mem", mem[2000], 0);

      @(negedge clk);
      w0 = wr_cnt;
      flush = 1'b1;
      req_valid = 1'b1;
      req_addr = 9;
      req_insert = 1'b1;
      #1;
      check("flush_ready", req_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      req_valid = 1'b0;
      seq_err = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         if (!(ram_cs && ram_we && ram_addr == AW'(i)
               && ram_wdata == '0 && busy))
            seq_err++;
      end
      @(negedge clk);
      check("sweep_seq", seq_err, 0);
      check("sweep_cnt", wr_cnt - w0, DEPTH);
      check("sweep_busy", busy, 0);
      check("sweep_full", dict_full, 0);
      check("sweep_mem5", mem[5], 0);
`ifdef DICT_STATS_EN
      check("st_hits_clr", stat_hits, 0);
      check("st_miss_clr", stat_misses, 0);
      check("st_ins_clr", stat_inserts, 0);
`endif
      do_req(5, 1, 0, 256, 4);

      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (ram_we && ram_addr == 100) found = 1'b1;
      end
      check("clr_reach", found, 1);
      rst = 1'b1;
      #1;
      check("mid_busy", busy, 0);
      check("mid_cs", ram_cs, 0);
      check("mid_we", ram_we, 0);
      check("mid_rsp", rsp_valid, 0);
      check("mid_ready", req_ready, 1);
      check("mid_code", rsp_code, 0);
      check("mid_full", dict_full, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_req(5, 1, 0, 256, 4);
      do_req(5, 0, 1, 256, 3);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
